busca_instrucao: RTL and testbench
==================================

Name: busca_instrucao

Overview:
- Instruction-fetch stage of the multicycle MIPS datapath. It sits directly downstream of the program counter.
- In the fetch phase of the cycle counter it samples the current PC (`endereco`) and performs a request/ready read of instruction memory.
- It holds the fetched word in the instruction register and returns PC+4 to the next-address mux that feeds the program counter.
- Sampling happens in phase 0, before the program counter's phase-1 update, so the address is always the pre-update PC.

Parameters:
- FASE_BUSCA, 0, value of `cont` in which a fetch is started.
- TIMEOUT, 15, maximum cycles spent waiting for `mem_pronto` before abandoning the fetch (1..255).
- NOP, 32'h00000000, word loaded into `instrucao` on an error.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cont  in  4  multicycle phase counter.
- endereco  in  32  current PC from the program counter.
- flush  in  1  branch/jump taken; discard any fetch in flight.
- mem_req  out  1  read request to instruction memory.
- mem_end  out  32  read address; stable while `mem_req` is 1.
- mem_pronto  in  1  memory data valid this cycle.
- mem_dado  in  32  memory read data.
- instrucao  out  32  instruction register.
- pc_mais4  out  32  latched fetch address + 4.
- instr_valida  out  1  one-cycle pulse: `instrucao` was just updated.
- ocupado  out  1  fetch in progress; the phase counter must stall.
- erro_alinhamento  out  1  sticky: misaligned fetch address.
- erro_timeout  out  1  sticky: memory did not answer within TIMEOUT cycles.

Behaviour:
- Reset (rst_n=0, asynchronous): state OCIOSO; all outputs 0; timeout counter 0; descarta flag 0.
- States: OCIOSO, AGUARDA, DESCARTA.
- OCIOSO, `cont`==FASE_BUSCA, `endereco[1:0]`==0:
  - latch `endereco` into `mem_end`;
  - `mem_req`=1 and `ocupado`=1 from the next cycle;
  - go to AGUARDA; timeout counter cleared.
- OCIOSO, `cont`==FASE_BUSCA, `endereco[1:0]`!=0:
  - no memory request;
  - next cycle: `instrucao`=NOP, `pc_mais4`=`endereco`+4, `erro_alinhamento`=1, `instr_valida` pulses;
  - stay in OCIOSO.
- OCIOSO, `cont`!=FASE_BUSCA: outputs hold; `instr_valida`=0.
- AGUARDA, normal completion: `mem_req` and `mem_end` are held constant until `mem_pronto`=1 is sampled. On that edge:
  - `instrucao`=`mem_dado`;
  - `pc_mais4`=`mem_end`+4 (mod 2^32, so 32'hFFFFFFFC wraps to 0);
  - `instr_valida` pulses next cycle;
  - `mem_req`=0, `ocupado`=0;
  - go to OCIOSO.
  - Latency: `mem_pronto` sampled on edge N means `instr_valida` is high in cycle N+1.
- AGUARDA, timeout counter: increments each cycle without `mem_pronto`. When it reaches TIMEOUT:
  - `mem_req`=0, `instrucao`=NOP, `erro_timeout`=1, `instr_valida` pulses;
  - go to OCIOSO.
- AGUARDA, `flush`=1: go to DESCARTA with `mem_req` still held, because the memory handshake is never aborted mid-request.
- DESCARTA: on `mem_pronto` (or timeout):
  - data is dropped;
  - `instrucao` and `pc_mais4` are unchanged and there is no `instr_valida` pulse;
  - `mem_req`=0, `ocupado`=0;
  - go to OCIOSO.
- Simultaneous `flush` and `mem_pronto` in AGUARDA: flush wins and the data is dropped.
- `flush` in OCIOSO has no effect.
- `cont`==FASE_BUSCA while in AGUARDA/DESCARTA: ignored; `ocupado` is already high.
- Sticky error flags clear only on reset.
- Reset asserted mid-fetch: immediate return to the reset values; `mem_req` drops asynchronously.

Decomposition:
- Shared package `mips_pkg`: state enum (OCIOSO/AGUARDA/DESCARTA), NOP constant, FASE_BUSCA default, word width 32.
- Sub-module `temporizador_espera`: loadable up-counter with clear, enable and `expirou` output. It is reused later for data-memory waits.

Test Plan:
- Basic fetch: `endereco`=0x40, `cont`=0, `mem_pronto` 2 cycles after `mem_req`, `mem_dado`=0x8C220004 -> `mem_end`=0x40, `instrucao`=0x8C220004, `pc_mais4`=0x44, single `instr_valida` pulse, `ocupado` high 3 cycles.
- Wrap: `endereco`=0xFFFFFFFC, immediate `mem_pronto` -> `pc_mais4`=0x00000000.
- Misaligned: `endereco`=0x42, `cont`=0 -> `mem_req` never rises, `instrucao`=0, `erro_alinhamento`=1, `instr_valida` pulse.
- Timeout: `mem_pronto` held 0 -> `mem_req` deasserts after 15 cycles, `erro_timeout`=1, `instrucao`=0.
- Flush: `flush`=1 in the cycle after `mem_req` rises, `mem_pronto` 3 cycles later with 0xDEADBEEF -> `instrucao`/`pc_mais4` keep their previous values, no `instr_valida`, `mem_req` held until `mem_pronto`.
- Reset mid-fetch: `rst_n`=0 during AGUARDA -> `mem_req`, `ocupado`, `instrucao` = 0 without waiting for a clock edge; next `cont`=0 starts a clean fetch.

Source files
------------

// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the multicycle MIPS datapath: word width, default
// fetch phase, NOP encoding, default memory-wait limit and the fetch-stage
// state type.
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam int unsigned LARGURA_PALAVRA = 32;
    localparam logic [3:0]  FASE_BUSCA_PADRAO = 4'd0;
    localparam int unsigned TIMEOUT_PADRAO    = 15;
    localparam logic [LARGURA_PALAVRA-1:0] NOP_PADRAO = '0;

    typedef enum logic [1:0] {
        OCIOSO,
        AGUARDA,
        DESCARTA
    } estado_busca_t;

endpackage

// File: rtl/temporizador_espera.sv
// -----------------------------------------------------------------------------
// temporizador_espera
// Loadable up-counter used to bound memory handshakes.
//   clk, rst_n  : clock / asynchronous active-low reset
//   i_limpa     : synchronous clear (highest priority)
//   i_carga     : synchronous load of i_valor
//   i_valor     : load value
//   i_en        : count enable
//   i_limite    : wait limit
//   o_expirou   : the increment taking place on this edge reaches i_limite
// -----------------------------------------------------------------------------
module temporizador_espera
    import mips_pkg::*;
#(
    parameter int unsigned LARGURA = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_limpa,
    input  logic               i_carga,
    input  logic [LARGURA-1:0] i_valor,
    input  logic               i_en,
    input  logic [LARGURA-1:0] i_limite,
    output logic               o_expirou
);

    logic [LARGURA-1:0] r_cont;
    logic [LARGURA-1:0] w_prox;

    assign w_prox = r_cont + 1'b1;

    // Flag the edge on which the count reaches the limit, so the owner can
    // give up on that same edge instead of one cycle later.
    assign o_expirou = i_en && (w_prox == i_limite);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cont <= '0;
        end else if (i_limpa) begin
            r_cont <= '0;
        end else if (i_carga) begin
            r_cont <= i_valor;
        end else if (i_en) begin
            r_cont <= w_prox;
        end
    end

endmodule

// File: rtl/busca_instrucao.sv
// -----------------------------------------------------------------------------
// busca_instrucao
// Instruction-fetch stage of the multicycle MIPS datapath. In the fetch phase
// it samples the current PC, reads instruction memory with a request/ready
// handshake, holds the word in the instruction register and returns PC+4.
//   clk, rst_n        : clock / asynchronous active-low reset
//   cont              : multicycle phase counter
//   endereco          : current PC
//   flush             : branch/jump taken, discard fetch in flight
//   mem_req, mem_end  : memory read request and address
//   mem_pronto        : memory data valid
//   mem_dado          : memory read data
//   instrucao         : instruction register
//   pc_mais4          : fetch address + 4
//   instr_valida      : one-cycle pulse, instrucao just updated
//   ocupado           : fetch in progress, phase counter must stall
//   erro_alinhamento  : sticky misaligned-address flag
//   erro_timeout      : sticky memory-timeout flag
// -----------------------------------------------------------------------------
module busca_instrucao
    import mips_pkg::*;
#(
    parameter logic [3:0]  FASE_BUSCA = FASE_BUSCA_PADRAO,
    parameter int unsigned TIMEOUT    = TIMEOUT_PADRAO,
    parameter logic [31:0] NOP        = NOP_PADRAO
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  cont,
    input  logic [31:0] endereco,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_end,
    input  logic        mem_pronto,
    input  logic [31:0] mem_dado,
    output logic [31:0] instrucao,
    output logic [31:0] pc_mais4,
    output logic        instr_valida,
    output logic        ocupado,
    output logic        erro_alinhamento,
    output logic        erro_timeout
);

    estado_busca_t r_estado;
    logic          r_mem_req;
    logic [31:0]   r_mem_end;
    logic [31:0]   r_instrucao;
    logic [31:0]   r_pc_mais4;
    logic          r_instr_valida;
    logic          r_ocupado;
    logic          r_erro_alinhamento;
    logic          r_erro_timeout;

    logic          w_limpa;
    logic          w_en;
    logic          w_expirou;

    // Counter is held at zero while idle, so every wait starts from zero; it
    // keeps running through DESCARTA so a dropped fetch is bounded too.
    assign w_limpa = (r_estado == OCIOSO);
    assign w_en    = (r_estado != OCIOSO) && !mem_pronto;

    temporizador_espera #(
        .LARGURA (8)
    ) u_temporizador (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_limpa   (w_limpa),
        .i_carga   (1'b0),
        .i_valor   (8'd0),
        .i_en      (w_en),
        .i_limite  (8'(TIMEOUT)),
        .o_expirou (w_expirou)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado           <= OCIOSO;
            r_mem_req          <= 1'b0;
            r_mem_end          <= '0;
            r_instrucao        <= '0;
            r_pc_mais4         <= '0;
            r_instr_valida     <= 1'b0;
            r_ocupado          <= 1'b0;
            r_erro_alinhamento <= 1'b0;
            r_erro_timeout     <= 1'b0;
        end else begin
            r_instr_valida <= 1'b0;
            case (r_estado)
                OCIOSO: begin
                    if (cont == FASE_BUSCA) begin
                        if (endereco[1:0] == 2'b00) begin
                            r_mem_end <= endereco;
                            r_mem_req <= 1'b1;
                            r_ocupado <= 1'b1;
                            r_estado  <= AGUARDA;
                        end else begin
                            r_instrucao        <= NOP;
                            r_pc_mais4         <= endereco + 32'd4;
                            r_erro_alinhamento <= 1'b1;
                            r_instr_valida     <= 1'b1;
                        end
                    end
                end
                AGUARDA: begin
                    if (flush) begin
                        // Flush wins; if the handshake also ends now there is
                        // nothing left to wait for, otherwise drain it.
                        if (mem_pronto || w_expirou) begin
                            r_mem_req <= 1'b0;
                            r_ocupado <= 1'b0;
                            r_estado  <= OCIOSO;
                        end else begin
                            r_estado <= DESCARTA;
                        end
                    end else if (mem_pronto) begin
                        r_instrucao    <= mem_dado;
                        r_pc_mais4     <= r_mem_end + 32'd4;
                        r_instr_valida <= 1'b1;
                        r_mem_req      <= 1'b0;
                        r_ocupado      <= 1'b0;
                        r_estado       <= OCIOSO;
                    end else if (w_expirou) begin
                        r_instrucao    <= NOP;
                        r_erro_timeout <= 1'b1;
                        r_instr_valida <= 1'b1;
                        r_mem_req      <= 1'b0;
                        r_ocupado      <= 1'b0;
                        r_estado       <= OCIOSO;
                    end
                end
                DESCARTA: begin
                    if (mem_pronto || w_expirou) begin
                        r_mem_req <= 1'b0;
                        r_ocupado <= 1'b0;
                        r_estado  <= OCIOSO;
                    end
                end
                default: begin
                    r_estado <= OCIOSO;
                end
            endcase
        end
    end

    assign mem_req          = r_mem_req;
    assign mem_end          = r_mem_end;
    assign instrucao        = r_instrucao;
    assign pc_mais4         = r_pc_mais4;
    assign instr_valida     = r_instr_valida;
    assign ocupado          = r_ocupado;
    assign erro_alinhamento = r_erro_alinhamento;
    assign erro_timeout     = r_erro_timeout;

endmodule

// File: tb/tb_busca_instrucao.sv
// -----------------------------------------------------------------------------
// tb_busca_instrucao
// Self-checking bench for busca_instrucao: directed scenarios plus random
// fetches compared against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_busca_instrucao;

    localparam int TIMEOUT = 15;
    localparam int JANELA  = 20;

    logic        clk;
    logic        rst_n;
    logic [3:0]  cont;
    logic [31:0] endereco;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_end;
    logic        mem_pronto;
    logic [31:0] mem_dado;
    logic [31:0] instrucao;
    logic [31:0] pc_mais4;
    logic        instr_valida;
    logic        ocupado;
    logic        erro_alinhamento;
    logic        erro_timeout;

    int errors = 0;
    int checks = 0;

    // reference model architectural state
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
    logic        exp_eal;
    logic        exp_eto;

    busca_instrucao #(
        .FASE_BUSCA (4'd0),
        .TIMEOUT    (TIMEOUT),
        .NOP        (32'h0000_0000)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cont             (cont),
        .endereco         (endereco),
        .flush            (flush),
        .mem_req          (mem_req),
        .mem_end          (mem_end),
        .mem_pronto       (mem_pronto),
        .mem_dado         (mem_dado),
        .instrucao        (instrucao),
        .pc_mais4         (pc_mais4),
        .instr_valida     (instr_valida),
        .ocupado          (ocupado),
        .erro_alinhamento (erro_alinhamento),
        .erro_timeout     (erro_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One fetch: cont=0 for one edge, then memory answers lat cycles after
    // the first request cycle; flush pulses in cycle flush_at (0 = never).
    // Collects what happened over a fixed window.
    task automatic do_fetch(input logic [31:0] addr, input int lat,
                            input logic [31:0] data, input int flush_at,
                            output int req_cyc, output int pulses,
                            output int end_bad, output int ocup_bad);
        req_cyc = 0; pulses = 0; end_bad = 0; ocup_bad = 0;
        @(negedge clk);
        cont = 4'd0; endereco = addr; mem_pronto = 1'b0; flush = 1'b0;
        mem_dado = data;
        for (int c = 1; c <= JANELA; c++) begin
            @(negedge clk);
            if (mem_req) begin
                req_cyc++;
                if (mem_end !== addr) end_bad++;
            end
            if (ocupado !== mem_req) ocup_bad++;
            if (instr_valida) pulses++;
            cont       = 4'd3;
            endereco   = $urandom;
            mem_pronto = (c == lat + 1);
            flush      = (c == flush_at);
        end
        mem_pronto = 1'b0;
        flush      = 1'b0;
    endtask

    // Transaction-level expectation for one fetch.
    task automatic model_fetch(input logic [31:0] addr, input int lat,
                               input logic [31:0] data, input int flush_at,
                               output int req_cyc, output int pulses);
        int fim;
        if (addr[1:0] != 2'b00) begin
            req_cyc   = 0;
            pulses    = 1;
            exp_instr = 32'h0;
            exp_pc    = addr + 32'd4;
            exp_eal   = 1'b1;
        end else begin
            fim     = (lat + 1 < TIMEOUT) ? lat + 1 : TIMEOUT;
            req_cyc = fim;
            if (flush_at != 0 && flush_at <= fim) begin
                pulses = 0;
            end else if (lat + 1 <= TIMEOUT) begin
                pulses    = 1;
                exp_instr = data;
                exp_pc    = addr + 32'd4;
            end else begin
                pulses    = 1;
                exp_instr = 32'h0;
                exp_eto   = 1'b1;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; cont = 4'd3; endereco = '0; flush = 1'b0;
        mem_pronto = 1'b0; mem_dado = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({mem_req, ocupado, instr_valida, erro_alinhamento, erro_timeout} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {mem_req, ocupado, instr_valida, erro_alinhamento, erro_timeout});
        end
        checks++;
        if ({instrucao, pc_mais4, mem_end} !== 96'h0) begin
            errors++;
            $display("FAIL reset_regs: got %h %h %h expected zeros", instrucao, pc_mais4, mem_end);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int rc, pu, eb, ob;
        do_fetch(32'h40, 2, 32'h8C22_0004, 0, rc, pu, eb, ob);
        checks++;
        if (rc !== 3) begin errors++; $display("FAIL basic_req_cycles: got %0d expected 3", rc); end
        checks++;
        if (ob !== 0) begin errors++; $display("FAIL basic_ocupado: got %0d bad cycles expected 0", ob); end
        checks++;
        if (eb !== 0 || mem_end !== 32'h40) begin
            errors++; $display("FAIL basic_mem_end: got %h (%0d bad) expected 00000040", mem_end, eb);
        end
        checks++;
        if (instrucao !== 32'h8C22_0004) begin
            errors++; $display("FAIL basic_instrucao: got %h expected 8c220004", instrucao);
        end
        checks++;
        if (pc_mais4 !== 32'h44) begin errors++; $display("FAIL basic_pc_mais4: got %h expected 00000044", pc_mais4); end
        checks++;
        if (pu !== 1) begin errors++; $display("FAIL basic_valida: got %0d pulses expected 1", pu); end
    endtask

    task automatic test_wrap;
        int rc, pu, eb, ob;
        do_fetch(32'hFFFF_FFFC, 0, 32'h2408_0001, 0, rc, pu, eb, ob);
        checks++;
        if (rc !== 1) begin errors++; $display("FAIL wrap_req_cycles: got %0d expected 1", rc); end
        checks++;
        if (pc_mais4 !== 32'h0) begin errors++; $display("FAIL wrap_pc_mais4: got %h expected 00000000", pc_mais4); end
        checks++;
        if (instrucao !== 32'h2408_0001) begin errors++; $display("FAIL wrap_instrucao: got %h expected 24080001", instrucao); end
    endtask

    task automatic test_flush;
        int rc, pu, eb, ob;
        // previous fetch left instrucao=24080001, pc_mais4=0
        do_fetch(32'h80, 4, 32'hDEAD_BEEF, 2, rc, pu, eb, ob);
        checks++;
        if (rc !== 5) begin errors++; $display("FAIL flush_req_held: got %0d cycles expected 5", rc); end
        checks++;
        if (pu !== 0) begin errors++; $display("FAIL flush_valida: got %0d pulses expected 0", pu); end
        checks++;
        if (instrucao !== 32'h2408_0001 || pc_mais4 !== 32'h0) begin
            errors++; $display("FAIL flush_hold: got %h %h expected 24080001 00000000", instrucao, pc_mais4);
        end
        checks++;
        if (ob !== 0) begin errors++; $display("FAIL flush_ocupado: got %0d bad cycles expected 0", ob); end
    endtask

    task automatic test_misaligned;
        int rc, pu, eb, ob;
        do_fetch(32'h42, 0, 32'h1234_5678, 0, rc, pu, eb, ob);
        checks++;
        if (rc !== 0) begin errors++; $display("FAIL mis_req: got %0d cycles expected 0", rc); end
        checks++;
        if (instrucao !== 32'h0 || pc_mais4 !== 32'h46) begin
            errors++; $display("FAIL mis_regs: got %h %h expected 00000000 00000046", instrucao, pc_mais4);
        end
        checks++;
        if (erro_alinhamento !== 1'b1 || erro_timeout !== 1'b0) begin
            errors++; $display("FAIL mis_flags: got %b%b expected 10", erro_alinhamento, erro_timeout);
        end
        checks++;
        if (pu !== 1) begin errors++; $display("FAIL mis_valida: got %0d pulses expected 1", pu); end
    endtask

    task automatic test_timeout;
        int rc, pu, eb, ob;
        do_fetch(32'h100, 99, 32'hCAFE_F00D, 0, rc, pu, eb, ob);
        checks++;
        if (rc !== TIMEOUT) begin errors++; $display("FAIL to_req_cycles: got %0d expected %0d", rc, TIMEOUT); end
        checks++;
        if (erro_timeout !== 1'b1) begin errors++; $display("FAIL to_flag: got %b expected 1", erro_timeout); end
        checks++;
        if (instrucao !== 32'h0) begin errors++; $display("FAIL to_instrucao: got %h expected 00000000", instrucao); end
        checks++;
        if (pu !== 1) begin errors++; $display("FAIL to_valida: got %0d pulses expected 1", pu); end
        checks++;
        if (erro_alinhamento !== 1'b1) begin errors++; $display("FAIL to_sticky_al: got %b expected 1", erro_alinhamento); end
    endtask

    task automatic test_reset_mid_fetch;
        int rc, pu, eb, ob;
        @(negedge clk);
        cont = 4'd0; endereco = 32'h200; mem_dado = 32'h1111_2222;
        @(negedge clk);
        cont = 4'd3;
        repeat (2) @(negedge clk);
        checks++;
        if (mem_req !== 1'b1) begin errors++; $display("FAIL rmid_pre: got mem_req=%b expected 1", mem_req); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || ocupado !== 1'b0 || instrucao !== 32'h0) begin
            errors++;
            $display("FAIL rmid_async: got req=%b ocup=%b instr=%h expected 0 0 00000000",
                     mem_req, ocupado, instrucao);
        end
        checks++;
        if (erro_alinhamento !== 1'b0 || erro_timeout !== 1'b0) begin
            errors++; $display("FAIL rmid_flags: got %b%b expected 00", erro_alinhamento, erro_timeout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_fetch(32'h300, 1, 32'hABCD_0123, 0, rc, pu, eb, ob);
        checks++;
        if (rc !== 2 || instrucao !== 32'hABCD_0123 || pc_mais4 !== 32'h304 || pu !== 1) begin
            errors++;
            $display("FAIL rmid_clean: got rc=%0d instr=%h pc=%h pulses=%0d expected 2 abcd0123 00000304 1",
                     rc, instrucao, pc_mais4, pu);
        end
    endtask

    task automatic test_random;
        int rc, pu, eb, ob, erc, epu, lat, fa;
        logic [31:0] addr, data;
        exp_instr = 32'hABCD_0123; exp_pc = 32'h304; exp_eal = 1'b0; exp_eto = 1'b0;
        for (int n = 0; n < 30; n++) begin
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            data = $urandom;
            lat  = $urandom_range(0, 16);
            fa   = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 16) : 0;
            model_fetch(addr, lat, data, fa, erc, epu);
            do_fetch(addr, lat, data, fa, rc, pu, eb, ob);
            checks++;
            if (rc !== erc || pu !== epu) begin
                errors++;
                $display("FAIL rnd%0d_handshake: got req=%0d pulses=%0d expected req=%0d pulses=%0d",
                         n, rc, pu, erc, epu);
            end
            checks++;
            if (eb !== 0 || ob !== 0) begin
                errors++; $display("FAIL rnd%0d_stable: got %0d/%0d bad cycles expected 0/0", n, eb, ob);
            end
            checks++;
            if (instrucao !== exp_instr || pc_mais4 !== exp_pc) begin
                errors++;
                $display("FAIL rnd%0d_regs: got %h %h expected %h %h", n, instrucao, pc_mais4, exp_instr, exp_pc);
            end
            checks++;
            if (erro_alinhamento !== exp_eal || erro_timeout !== exp_eto) begin
                errors++;
                $display("FAIL rnd%0d_flags: got %b%b expected %b%b", n,
                         erro_alinhamento, erro_timeout, exp_eal, exp_eto);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_flush();
        test_misaligned();
        test_timeout();
        test_reset_mid_fetch();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
